// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control sequencer to datapath handshake and strobe bundle
interface control_sequencer_if;
  logic        start;
  logic [15:0] ir;
  logic        dr_zero;
  logic        load_PC;
  logic        load_AR;
  logic        load_IR;
  logic        load_DR;
  logic        load_AC;
  logic        increment_PC;
  logic        increment_AR;
  logic        increment_DR;
  logic        increment_AC;
  logic        clear_AC;
  logic        clear_SC_dbg;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  bus_sel;
  logic [1:0]  alu_op;
  logic [2:0]  t_state;
  logic        halted;

  modport master (
    input  start, ir, dr_zero,
    output load_PC, load_AR, load_IR, load_DR, load_AC,
    output increment_PC, increment_AR, increment_DR, increment_AC,
    output clear_AC, clear_SC_dbg, mem_read, mem_write,
    output bus_sel, alu_op, t_state, halted
  );

  modport slave (
    output start, ir, dr_zero,
    input  load_PC, load_AR, load_IR, load_DR, load_AC,
    input  increment_PC, increment_AR, increment_DR, increment_AC,
    input  clear_AC, clear_SC_dbg, mem_read, mem_write,
    input  bus_sel, alu_op, t_state, halted
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/indirect/execute control sequencer for a basic accumulator CPU
module control_sequencer (
  input logic                 clk,
  input logic                 rst,
  control_sequencer_if.master bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0] state;
  logic [2:0] sc;
  logic       i_bit;
  logic [2:0] opcode;
  logic       end_instr;
  logic       halt_req;
  logic       undef;

  logic unused_ir;
  assign unused_ir = ^{bus.ir[10:6], bus.ir[4:1]};

  assign bus.t_state      = sc;
  assign bus.halted       = (state == S_HALTED);
  assign bus.clear_SC_dbg = end_instr;

  always_comb begin
    bus.load_PC      = 1'b0;
    bus.load_AR      = 1'b0;
    bus.load_IR      = 1'b0;
    bus.load_DR      = 1'b0;
    bus.load_AC      = 1'b0;
    bus.increment_PC = 1'b0;
    bus.increment_AR = 1'b0;
    bus.increment_DR = 1'b0;
    bus.increment_AC = 1'b0;
    bus.clear_AC     = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.bus_sel      = 3'd0;
    bus.alu_op       = 2'd0;
    end_instr        = 1'b0;
    halt_req         = 1'b0;
    undef            = 1'b0;
    if (state == S_RUN) begin
      case (sc)
        3'd0: begin
          bus.bus_sel = 3'd2;
          bus.load_AR = 1'b1;
        end
        3'd1: begin
          bus.bus_sel      = 3'd7;
          bus.mem_read     = 1'b1;
          bus.load_IR      = 1'b1;
          bus.increment_PC = 1'b1;
        end
        3'd2: begin
          bus.bus_sel = 3'd5;
          bus.load_AR = 1'b1;
        end
        3'd3: begin
          // Register-reference bits come straight from IR; opcode/I were latched at T2
          if (opcode == 3'd7) begin
            end_instr = 1'b1;
            if (!i_bit) begin
              bus.clear_AC     = bus.ir[11];
              bus.increment_AC = bus.ir[5];
              halt_req         = bus.ir[0];
            end
          end else if (i_bit) begin
            bus.bus_sel  = 3'd7;
            bus.mem_read = 1'b1;
            bus.load_AR  = 1'b1;
          end
        end
        3'd4: begin
          case (opcode)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              bus.bus_sel  = 3'd7;
              bus.mem_read = 1'b1;
              bus.load_DR  = 1'b1;
            end
            3'd3: begin
              bus.bus_sel   = 3'd4;
              bus.mem_write = 1'b1;
              end_instr     = 1'b1;
            end
            3'd4: begin
              bus.bus_sel = 3'd1;
              bus.load_PC = 1'b1;
              end_instr   = 1'b1;
            end
            3'd5: begin
              bus.bus_sel      = 3'd2;
              bus.mem_write    = 1'b1;
              bus.increment_AR = 1'b1;
            end
            default: undef = 1'b1;
          endcase
        end
        3'd5: begin
          case (opcode)
            3'd0, 3'd1, 3'd2: begin
              bus.load_AC = 1'b1;
              bus.alu_op  = opcode[1:0];
              end_instr   = 1'b1;
            end
            3'd5: begin
              bus.bus_sel = 3'd1;
              bus.load_PC = 1'b1;
              end_instr   = 1'b1;
            end
            3'd6: bus.increment_DR = 1'b1;
            default: undef = 1'b1;
          endcase
        end
        3'd6: begin
          if (opcode == 3'd6) begin
            bus.bus_sel      = 3'd3;
            bus.mem_write    = 1'b1;
            bus.increment_PC = bus.dr_zero;
            end_instr        = 1'b1;
          end else begin
            undef = 1'b1;
          end
        end
        default: undef = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sc     <= 3'd0;
      i_bit  <= 1'b0;
      opcode <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          sc <= 3'd0;
          if (bus.start) state <= S_RUN;
        end
        S_RUN: begin
          if (sc == 3'd2) begin
            i_bit  <= bus.ir[15];
            opcode <= bus.ir[14:12];
          end
          if (halt_req) begin
            state <= S_HALTED;
            sc    <= 3'd0;
          end else if (end_instr || undef) begin
            sc <= 3'd0;
          end else begin
            sc <= sc + 3'd1;
          end
        end
        S_HALTED: sc <= 3'd0;
        default: begin
          state <= S_IDLE;
          sc    <= 3'd0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - table-driven bench for control_sequencer
module tb_control_sequencer;
  localparam logic [12:0] LPC = 13'h1000, LAR = 13'h0800, LIR = 13'h0400, LDR = 13'h0200;
  localparam logic [12:0] LAC = 13'h0100, IPC = 13'h0080, IAR = 13'h0040, IDR = 13'h0020;
  localparam logic [12:0] IAC = 13'h0010, CAC = 13'h0008, CSC = 13'h0004, MR  = 13'h0002;
  localparam logic [12:0] MW  = 13'h0001;

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] ir;
    logic        dz;
    logic [21:0] exp;
    logic        chk;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  control_sequencer_if bus_if();

  control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  logic [21:0] dut_out;
  assign dut_out = {bus_if.load_PC, bus_if.load_AR, bus_if.load_IR, bus_if.load_DR,
                    bus_if.load_AC, bus_if.increment_PC, bus_if.increment_AR,
                    bus_if.increment_DR, bus_if.increment_AC, bus_if.clear_AC,
                    bus_if.clear_SC_dbg, bus_if.mem_read, bus_if.mem_write,
                    bus_if.bus_sel, bus_if.alu_op, bus_if.t_state, bus_if.halted};

  task automatic add(input logic r, input logic s, input logic [15:0] i, input logic dz,
                     input logic [12:0] st, input logic [2:0] b, input logic [1:0] a,
                     input logic [2:0] t, input logic h, input logic c, input string n);
    vec_t v;
    v.rst = r; v.start = s; v.ir = i; v.dz = dz;
    v.exp = {st, b, a, t, h}; v.chk = c; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic fetch(input logic [15:0] i, input logic s, input string n);
    add(0, s, i, 0, LAR,          3'd2, 2'd0, 3'd0, 0, 1, {n, " T0"});
    add(0, s, i, 0, MR | LIR | IPC, 3'd7, 2'd0, 3'd1, 0, 1, {n, " T1"});
    add(0, s, i, 0, LAR,          3'd5, 2'd0, 3'd2, 0, 1, {n, " T2"});
  endtask

  task automatic check(input string n, input logic [21:0] got, input logic [21:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  initial begin
    bus_if.start = 1'b0; bus_if.ir = 16'h0; bus_if.dr_zero = 1'b0;

    add(1, 0, 16'h0, 0, 13'h0, 3'd0, 2'd0, 3'd0, 0, 0, "reset apply");
    add(0, 0, 16'h0, 0, 13'h0, 3'd0, 2'd0, 3'd0, 0, 1, "idle after reset");
    add(0, 1, 16'h2005, 0, 13'h0, 3'd0, 2'd0, 3'd0, 0, 1, "idle with start");
    fetch(16'h2005, 0, "lda");
    add(0, 0, 16'h2005, 0, 13'h0,     3'd0, 2'd0, 3'd3, 0, 1, "lda T3");
    add(0, 0, 16'h2005, 0, MR | LDR,  3'd7, 2'd0, 3'd4, 0, 1, "lda T4");
    add(0, 0, 16'h2005, 0, LAC | CSC, 3'd0, 2'd2, 3'd5, 0, 1, "lda T5");
    fetch(16'h9010, 0, "add_ind");
    add(0, 0, 16'h9010, 0, MR | LAR,  3'd7, 2'd0, 3'd3, 0, 1, "add_ind T3");
    add(0, 0, 16'h9010, 0, MR | LDR,  3'd7, 2'd0, 3'd4, 0, 1, "add_ind T4");
    add(0, 0, 16'h9010, 0, LAC | CSC, 3'd0, 2'd1, 3'd5, 0, 1, "add_ind T5");
    fetch(16'h6020, 0, "isz_z");
    add(0, 0, 16'h6020, 0, 13'h0,          3'd0, 2'd0, 3'd3, 0, 1, "isz_z T3");
    add(0, 0, 16'h6020, 0, MR | LDR,       3'd7, 2'd0, 3'd4, 0, 1, "isz_z T4");
    add(0, 0, 16'h6020, 0, IDR,            3'd0, 2'd0, 3'd5, 0, 1, "isz_z T5");
    add(0, 0, 16'h6020, 1, MW | IPC | CSC, 3'd3, 2'd0, 3'd6, 0, 1, "isz_z T6");
    fetch(16'h6020, 0, "isz_nz");
    add(0, 0, 16'h6020, 0, 13'h0,    3'd0, 2'd0, 3'd3, 0, 1, "isz_nz T3");
    add(0, 0, 16'h6020, 0, MR | LDR, 3'd7, 2'd0, 3'd4, 0, 1, "isz_nz T4");
    add(0, 0, 16'h6020, 0, IDR,      3'd0, 2'd0, 3'd5, 0, 1, "isz_nz T5");
    add(0, 0, 16'h6020, 0, MW | CSC, 3'd3, 2'd0, 3'd6, 0, 1, "isz_nz T6");
    fetch(16'h5030, 1, "bsa start_ignored");
    add(0, 1, 16'h5030, 0, 13'h0,     3'd0, 2'd0, 3'd3, 0, 1, "bsa T3");
    add(0, 0, 16'h5030, 0, MW | IAR,  3'd2, 2'd0, 3'd4, 0, 1, "bsa T4");
    add(0, 0, 16'h5030, 0, LPC | CSC, 3'd1, 2'd0, 3'd5, 0, 1, "bsa T5");
    fetch(16'h3000, 0, "sta");
    add(0, 0, 16'h3000, 0, 13'h0,     3'd0, 2'd0, 3'd3, 0, 1, "sta T3");
    add(0, 0, 16'h3000, 0, MW | CSC,  3'd4, 2'd0, 3'd4, 0, 1, "sta T4");
    fetch(16'h4000, 0, "bun");
    add(0, 0, 16'h4000, 0, 13'h0,     3'd0, 2'd0, 3'd3, 0, 1, "bun T3");
    add(0, 0, 16'h4000, 0, LPC | CSC, 3'd1, 2'd0, 3'd4, 0, 1, "bun T4");
    fetch(16'h0000, 0, "and");
    add(0, 0, 16'h0000, 0, 13'h0,     3'd0, 2'd0, 3'd3, 0, 1, "and T3");
    add(0, 0, 16'h0000, 0, MR | LDR,  3'd7, 2'd0, 3'd4, 0, 1, "and T4");
    add(0, 0, 16'h0000, 0, LAC | CSC, 3'd0, 2'd0, 3'd5, 0, 1, "and T5");
    fetch(16'hF000, 0, "io");
    add(0, 0, 16'hF000, 0, CSC,             3'd0, 2'd0, 3'd3, 0, 1, "io T3");
    fetch(16'h7820, 0, "cla_inc");
    add(0, 0, 16'h7820, 0, CAC | IAC | CSC, 3'd0, 2'd0, 3'd3, 0, 1, "cla_inc T3");
    fetch(16'h7001, 0, "hlt");
    add(0, 0, 16'h7001, 0, CSC,   3'd0, 2'd0, 3'd3, 0, 1, "hlt T3");
    add(0, 1, 16'h7001, 0, 13'h0, 3'd0, 2'd0, 3'd0, 1, 1, "halted start1");
    add(0, 1, 16'h7001, 0, 13'h0, 3'd0, 2'd0, 3'd0, 1, 1, "halted start2");
    add(1, 0, 16'h7001, 0, 13'h0, 3'd0, 2'd0, 3'd0, 1, 1, "halted rst cycle");
    add(0, 0, 16'h7001, 0, 13'h0, 3'd0, 2'd0, 3'd0, 0, 1, "idle after halt rst");
    add(0, 1, 16'h1010, 0, 13'h0, 3'd0, 2'd0, 3'd0, 0, 1, "abort idle start");
    fetch(16'h1010, 0, "abort_add");
    add(0, 0, 16'h1010, 0, 13'h0,    3'd0, 2'd0, 3'd3, 0, 1, "abort_add T3");
    add(1, 1, 16'h1010, 0, MR | LDR, 3'd7, 2'd0, 3'd4, 0, 1, "abort_add T4 rst");
    add(0, 0, 16'h1010, 0, 13'h0,    3'd0, 2'd0, 3'd0, 0, 1, "after abort 1");
    add(0, 0, 16'h1010, 0, 13'h0,    3'd0, 2'd0, 3'd0, 0, 1, "after abort 2");

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst;
      bus_if.start = vecs[k].start;
      bus_if.ir = vecs[k].ir;
      bus_if.dr_zero = vecs[k].dz;
      #1;
      if (vecs[k].chk) check(vecs[k].name, dut_out, vecs[k].exp);
    end

    // Hand sequence: launch BUN from IDLE and wait, bounded, for its end marker
    begin
      bit found;
      found = 1'b0;
      @(negedge clk);
      rst = 1'b0; bus_if.start = 1'b1; bus_if.ir = 16'h4123; bus_if.dr_zero = 1'b0;
      @(negedge clk);
      bus_if.start = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
        #1;
        if (bus_if.clear_SC_dbg) found = 1'b1;
        else @(negedge clk);
      end
      check("bun end seen", {21'd0, found}, 22'd1);
      check("bun end at T4", {19'd0, bus_if.t_state}, 22'd4);
      @(negedge clk);
      #1;
      check("bun next fetch T0", dut_out, {LAR, 3'd2, 2'd0, 3'd0, 1'b0});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
